imm_extend_pipe: RTL and testbench

//  Registered, parametrised immediate-extension stage for the MIPS decode->execute path.

---
 rtl/imm_ext_pkg.sv | 18 +
 rtl/imm_ext_core.sv | 36 +++
 rtl/imm_extend_pipe.sv | 116 +++++++++++
 tb/tb_imm_extend_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for immediate extension.
//   IMM_SEXT/IMM_ZEXT/IMM_UPPER/IMM_BRANCH : 2-bit mode encodings used by decode,
//                                            the control unit and the extend stage
//   width_ok()                             : legal width combination check
package imm_ext_pkg;

   localparam logic [1:0] IMM_SEXT   = 2'd0;
   localparam logic [1:0] IMM_ZEXT   = 2'd1;
   localparam logic [1:0] IMM_UPPER  = 2'd2;
   localparam logic [1:0] IMM_BRANCH = 2'd3;

   // A branch offset must fit after the shift, so the output needs room for
   // every input bit plus the shifted-in zeros.
   function automatic bit width_ok(input int in_w, input int out_w, input int br_shift);
      return (out_w >= in_w + br_shift);
   endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension.
//   in_imm  [IN_W]  : raw immediate
//   in_mode [2]     : IMM_SEXT / IMM_ZEXT / IMM_UPPER / IMM_BRANCH
//   out_imm [OUT_W] : extended immediate
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 32,
   parameter int BR_SHIFT = 2
) (
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic [OUT_W-1:0] out_imm
);

   logic [OUT_W-1:0] zx;
   logic [OUT_W-1:0] sx;

   // Size casts avoid a zero-width replication when OUT_W == IN_W.
   assign zx = OUT_W'(in_imm);
   assign sx = OUT_W'($signed(in_imm));

   always_comb begin
      out_imm = sx;
      unique case (in_mode)
         IMM_SEXT:   out_imm = sx;
         IMM_ZEXT:   out_imm = zx;
         // Shifting the OUT_W-wide value drops any bits above OUT_W.
         IMM_UPPER:  out_imm = zx << (OUT_W - IN_W);
         IMM_BRANCH: out_imm = sx << BR_SHIFT;
         default:    out_imm = sx;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer.
//   clk, rst_n           : clock, async active-low reset
//   flush                : synchronous discard of all held entries
//   in_valid/in_ready    : input handshake (in_ready is a flop output)
//   in_imm/in_mode/in_tag: immediate, extension mode, sideband tag
//   out_valid/out_ready  : output handshake
//   out_imm/out_tag      : extended immediate and its tag
module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 32,
   parameter int BR_SHIFT = 2,
   parameter int TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [TAG_W-1:0] out_tag
);

   generate
      if (!width_ok(IN_W, OUT_W, BR_SHIFT)) begin : g_bad_width
         $error("imm_extend_pipe: OUT_W must be >= IN_W + BR_SHIFT");
      end
   endgenerate

   logic [OUT_W-1:0] ext_imm;

   imm_ext_core #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .BR_SHIFT(BR_SHIFT)
   ) u_core (
      .in_imm (in_imm),
      .in_mode(in_mode),
      .out_imm(ext_imm)
   );

   logic             main_v_q,   main_v_d;
   logic [OUT_W-1:0] main_imm_q, main_imm_d;
   logic [TAG_W-1:0] main_tag_q, main_tag_d;
   logic             skid_v_q,   skid_v_d;
   logic [OUT_W-1:0] skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

   logic accept;
   logic main_free;

   assign accept    = in_valid && !skid_v_q;
   // Main can take new data if it is empty or its entry leaves this edge.
   assign main_free = !main_v_q || out_ready;

   always_comb begin
      main_v_d   = main_v_q;
      main_imm_d = main_imm_q;
      main_tag_d = main_tag_q;
      skid_v_d   = skid_v_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (main_free) begin
         if (skid_v_q) begin
            // Skid drains first; input was blocked since in_ready was low.
            main_v_d   = 1'b1;
            main_imm_d = skid_imm_q;
            main_tag_d = skid_tag_q;
            skid_v_d   = 1'b0;
         end else begin
            main_v_d = accept;
            if (accept) begin
               main_imm_d = ext_imm;
               main_tag_d = in_tag;
            end
         end
      end else if (accept) begin
         skid_v_d   = 1'b1;
         skid_imm_d = ext_imm;
         skid_tag_d = in_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v_q   <= 1'b0;
         main_imm_q <= '0;
         main_tag_q <= '0;
         skid_v_q   <= 1'b0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
      end else begin
         main_v_q   <= main_v_d;
         main_imm_q <= main_imm_d;
         main_tag_q <= main_tag_d;
         skid_v_q   <= skid_v_d;
         skid_imm_q <= skid_imm_d;
         skid_tag_q <= skid_tag_d;
      end
   end

   assign in_ready  = !skid_v_q;
   assign out_valid = main_v_q;
   assign out_imm   = main_imm_q;
   assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_imm = '0;
   logic [1:0]  in_mode = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_imm;
   logic [4:0]  out_tag;

   logic        i8_valid = 1'b0;
   logic        i8_ready;
   logic [7:0]  i8_imm = '0;
   logic [1:0]  i8_mode = '0;
   logic [4:0]  i8_tag = '0;
   logic        o8_valid;
   logic [15:0] o8_imm;
   logic [4:0]  o8_tag;

   always #5 clk = ~clk;

   imm_extend_pipe dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_tag(out_tag)
   );

   imm_extend_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1), .TAG_W(5)) dut8 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .in_valid(i8_valid), .in_ready(i8_ready), .in_imm(i8_imm),
      .in_mode(i8_mode), .in_tag(i8_tag),
      .out_valid(o8_valid), .out_ready(1'b1),
      .out_imm(o8_imm), .out_tag(o8_tag)
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference extension for the default 16->32 instance, from plain arithmetic.
   function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
      int s;
      s = imm[15] ? int'(imm) - 65536 : int'(imm);
      case (mode)
         2'd0:    return 32'(s);
         2'd1:    return 32'(int'(imm));
         2'd2:    return 32'(int'(imm) * 65536);
         default: return 32'(s * 4);
      endcase
   endfunction

   typedef struct {
      logic [31:0] imm;
      logic [4:0]  tag;
   } entry_t;

   entry_t    q[$];
   logic [4:0] popped[$];
   int        n_out = 0;

   // Model: a 2-deep FIFO whose contents the DUT must present in order.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else begin
         bit acc;
         entry_t e;
         acc = in_valid && (q.size() < 2);
         e.imm = model_ext(in_imm, in_mode);
         e.tag = in_tag;
         if (q.size() > 0 && out_ready) begin
            popped.push_back(q[0].tag);
            n_out++;
            void'(q.pop_front());
         end
         if (acc) q.push_back(e);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cmp_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
         chk("cmp_in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
         if (q.size() > 0) begin
            chk("cmp_out_imm", out_imm, q[0].imm);
            chk("cmp_out_tag", {27'b0, out_tag}, {27'b0, q[0].tag});
         end
      end
   end

   task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
      in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send8(input logic [7:0] imm, input logic [1:0] mode, input logic [15:0] exp,
                        input string name);
      i8_valid = 1'b1; i8_imm = imm; i8_mode = mode;
      @(posedge clk); #1;
      i8_valid = 1'b0;
      chk({name, "_valid"}, {31'b0, o8_valid}, 32'd1);
      chk(name, {16'b0, o8_imm}, {16'b0, exp});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int n0;
      int budget;
      logic [4:0] exp_tags[3];
      // Reset state
      #2;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_tag", {27'b0, out_tag}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      idle(1);

      // Modes, each visible one cycle after accept
      chk("model_sext", model_ext(16'hFF92, 2'd0), 32'hFFFFFF92);
      chk("model_branch", model_ext(16'hFFFF, 2'd3), 32'hFFFFFFFC);
      send(16'd20, 2'd0, 5'd1);    chk("sext_pos", out_imm, 32'h00000014);
      chk("lat1_valid", {31'b0, out_valid}, 32'd1);
      send(16'hFF92, 2'd0, 5'd2);  chk("sext_neg", out_imm, 32'hFFFFFF92);
      send(16'hFF92, 2'd1, 5'd3);  chk("zext", out_imm, 32'h0000FF92);
      send(16'h1234, 2'd2, 5'd4);  chk("upper", out_imm, 32'h12340000);
      send(16'hFFFF, 2'd3, 5'd5);  chk("branch", out_imm, 32'hFFFFFFFC);
      chk("branch_tag", {27'b0, out_tag}, 32'd5);
      idle(2);

      // Streaming
      n0 = n_out;
      for (int i = 0; i < 8; i++) begin
         send(16'(i * 300 - 1000), 2'd0, 5'(i));
         chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
         in_valid = 1'b1;
      end
      in_valid = 1'b0;
      idle(2);
      chk("stream_count", n_out - n0, 8);

      // Backpressure
      popped.delete();
      out_ready = 1'b0;
      send(16'h000A, 2'd0, 5'd1);
      send(16'h000B, 2'd1, 5'd2);
      chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
      in_valid = 1'b1; in_imm = 16'h000C; in_mode = 2'd2; in_tag = 5'd3;
      idle(2);
      chk("bp_held_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_held_tag", {27'b0, out_tag}, 32'd1);
      out_ready = 1'b1;
      budget = 20;
      while (!in_ready && budget > 0) begin idle(1); budget--; end
      chk("bp_wait_timeout", {31'b0, budget == 0}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      idle(3);
      exp_tags = '{5'd1, 5'd2, 5'd3};
      chk("bp_count", popped.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < popped.size()) chk("bp_order", {27'b0, popped[i]}, {27'b0, exp_tags[i]});

      // Flush with both entries held, then with only main held
      popped.delete();
      out_ready = 1'b0;
      send(16'h0004, 2'd0, 5'd4);
      send(16'h0005, 2'd0, 5'd5);
      in_valid = 1'b1; in_imm = 16'h0009; in_tag = 5'd9; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
      send(16'h0006, 2'd0, 5'd6);
      in_valid = 1'b1; in_imm = 16'h0009; in_tag = 5'd9; flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush2_out_valid", {31'b0, out_valid}, 32'd0);
      idle(3);
      chk("flush_no_output", popped.size(), 0);

      // Asynchronous reset between edges with two entries held
      out_ready = 1'b0;
      send(16'h0011, 2'd0, 5'd11);
      send(16'h0012, 2'd0, 5'd12);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_out_imm", out_imm, 32'd0);
      chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk); #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(16'h8000, 2'd0, 5'd13);
      chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
      chk("post_rst_imm", out_imm, 32'hFFFF8000);
      idle(2);

      // Narrow instance: IN_W=8, OUT_W=16, BR_SHIFT=1
      send8(8'h80, 2'd0, 16'hFF80, "p8_sext");
      send8(8'hC0, 2'd3, 16'hFF80, "p8_branch");
      send8(8'hAB, 2'd2, 16'hAB00, "p8_upper");
      send8(8'hAB, 2'd1, 16'h00AB, "p8_zext");
      chk("p8_in_ready", {31'b0, i8_ready}, 32'd1);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
